// File: rtl/spi_display_ctrl.sv
// SPI-programmed multiplexed 7-segment display controller (digit regs, enable mask, hex/raw mode, MISO echo).
// Writes land 1 cycle after the synchronised ss rise and show on segment_o the next cycle; no backpressure.
module spi_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 5000
) (
    input  logic                  clock_i,
    input  logic                  rst_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_ss_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic [7:0]            segment_o,
    output logic [NUM_DIGITS-1:0] digit_o,
    output logic                  frame_err_o
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [1:0]  flush;
    logic        armed;
    logic        in_frame;
    logic [4:0]  bit_cnt;
    logic [15:0] shift;
    logic        commit_pend;
    logic        commit_ok;
    logic [15:0] echo;
    logic [15:0] tx;

    logic [7:0]            digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] mask;
    logic                  mode;

    logic [CW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic [7:0]    cur_dig;
    logic [7:0]    seg_next;

    assign sclk_rise = ~sclk_prev & sclk_sync;
    assign sclk_fall = sclk_prev & ~sclk_sync;
    assign ss_rise   = ~ss_prev & ss_sync;
    assign ss_fall   = ss_prev & ~ss_sync;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            sclk_meta   <= 1'b1;
            sclk_sync   <= 1'b1;
            sclk_prev   <= 1'b1;
            ss_meta     <= 1'b1;
            ss_sync     <= 1'b1;
            ss_prev     <= 1'b1;
            mosi_meta   <= 1'b1;
            mosi_sync   <= 1'b1;
            flush       <= 2'b00;
            armed       <= 1'b0;
            in_frame    <= 1'b0;
            bit_cnt     <= 5'd0;
            shift       <= 16'h0000;
            commit_pend <= 1'b0;
            commit_ok   <= 1'b0;
            echo        <= 16'h0000;
            tx          <= 16'hFFFF;
            spi_miso_o  <= 1'b1;
            frame_err_o <= 1'b0;
            mask        <= '1;
            mode        <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 8'h00;
        end else begin
            sclk_meta   <= spi_sclk_i;
            sclk_sync   <= sclk_meta;
            sclk_prev   <= sclk_sync;
            ss_meta     <= spi_ss_i;
            ss_sync     <= ss_meta;
            ss_prev     <= ss_sync;
            mosi_meta   <= spi_mosi_i;
            mosi_sync   <= mosi_meta;
            frame_err_o <= 1'b0;
            commit_pend <= 1'b0;

            // A frame interrupted by reset must not resume: only accept a fall once ss has been seen idle.
            flush <= {flush[0], 1'b1};
            if (flush[1] && ss_sync) armed <= 1'b1;

            // The first sclk fall leads bit 0, so MISO only advances after a bit has been sampled.
            if (ss_fall && armed) begin
                in_frame   <= 1'b1;
                bit_cnt    <= 5'd0;
                spi_miso_o <= echo[15];
                tx         <= {echo[14:0], 1'b1};
            end else if (ss_sync) begin
                spi_miso_o <= 1'b1;
            end else if (in_frame && sclk_fall && bit_cnt != 5'd0) begin
                spi_miso_o <= tx[15];
                tx         <= {tx[14:0], 1'b1};
            end

            if (in_frame && !ss_sync && sclk_rise) begin
                shift <= {shift[14:0], mosi_sync};
                if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
            end

            if (in_frame && ss_rise) begin
                in_frame    <= 1'b0;
                commit_pend <= 1'b1;
                commit_ok   <= (bit_cnt == 5'd16);
            end

            if (commit_pend) begin
                if (!commit_ok) begin
                    frame_err_o <= 1'b1;
                end else begin
                    case (shift[15:12])
                        4'h0: echo <= shift;
                        4'h1: begin
                            if (int'(shift[11:8]) < NUM_DIGITS) begin
                                digits[shift[IW+7:8]] <= shift[7:0];
                                echo <= shift;
                            end else begin
                                frame_err_o <= 1'b1;
                            end
                        end
                        4'h2: begin
                            mask <= shift[NUM_DIGITS-1:0];
                            echo <= shift;
                        end
                        4'h3: begin
                            mode <= shift[0];
                            echo <= shift;
                        end
                        default: frame_err_o <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign cur_dig  = digits[idx];
    assign seg_next = mode ? ~cur_dig : {~cur_dig[7], hex7(cur_dig[3:0])};

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            scan_cnt  <= '0;
            idx       <= '0;
            segment_o <= 8'hFF;
            digit_o   <= '1;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (mask[idx]) begin
                digit_o   <= ~(NUM_DIGITS'(1) << idx);
                segment_o <= seg_next;
            end else begin
                digit_o   <= '1;
                segment_o <= 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_spi_display_ctrl.sv
// Bench for spi_display_ctrl: frame table with slot probes, random frames against a register-level model,
// continuous display/MISO checking, and hand sequences for mid-frame reset and the small-config scan.
module tb_spi_display_ctrl;
    localparam int H  = 6;
    localparam int N1 = 8;
    localparam int D1 = 40;
    localparam int N2 = 4;
    localparam int D2 = 3;

    logic clk = 1'b0;
    logic rst, sclk, ss, ss4, mosi;
    logic miso, miso4, err, err4;
    logic [7:0] seg, seg4, dig;
    logic [3:0] dig4;

    always #5 clk = ~clk;

    spi_display_ctrl #(.NUM_DIGITS(N1), .SCAN_DIV(D1)) u_dut (
        .clock_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_ss_i(ss), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .segment_o(seg), .digit_o(dig), .frame_err_o(err)
    );

    spi_display_ctrl #(.NUM_DIGITS(N2), .SCAN_DIV(D2)) u_dut4 (
        .clock_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_ss_i(ss4), .spi_mosi_i(mosi),
        .spi_miso_o(miso4), .segment_o(seg4), .digit_o(dig4), .frame_err_o(err4)
    );

    int vec_cnt = 0;
    int miscmp  = 0;
    int since   = 0;
    int err_cnt = 0;
    int err4_cnt = 0;
    logic chk_en = 1'b0;
    logic idle   = 1'b1;

    logic [7:0]  m_dig [8];
    logic [7:0]  m_mask;
    logic        m_mode;
    logic [15:0] m_echo;

    logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [31:0] frame;
        int          nb;
        int          err;
        int          slot;
        logic [7:0]  dig;
        logic [7:0]  seg;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
        m_mask = 8'hFF;
        m_mode = 1'b0;
        m_echo = 16'h0000;
    endtask

    task automatic model_commit(input logic [15:0] f, input int nb, output int e);
        e = 0;
        if (nb != 16) e = 1;
        else begin
            case (f[15:12])
                4'h0: m_echo = f;
                4'h1: if (f[11:8] < 4'd8) begin m_dig[f[10:8]] = f[7:0]; m_echo = f; end else e = 1;
                4'h2: begin m_mask = f[7:0]; m_echo = f; end
                4'h3: begin m_mode = f[0]; m_echo = f; end
                default: e = 1;
            endcase
        end
    endtask

    always @(posedge clk) since <= rst ? 0 : since + 1;

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (err4 === 1'b1) err4_cnt++;
    end

    int ci, cj;
    logic [7:0] cd, e_seg, e_dig;
    always @(negedge clk) begin
        if (chk_en) begin
            if (since == 0) begin
                check("rst_seg", seg, 8'hFF);
                check("rst_dig", dig, 8'hFF);
                check("rst_miso", miso, 1);
                check("rst_seg4", seg4, 8'hFF);
                check("rst_dig4", dig4, 4'hF);
            end else begin
                ci = ((since - 1) / D1) % N1;
                cd = m_dig[ci];
                if (m_mask[ci]) begin
                    e_dig = ~(8'd1 << ci);
                    e_seg = m_mode ? ~cd : {~cd[7], hex7[cd[3:0]]};
                end else begin
                    e_dig = 8'hFF;
                    e_seg = 8'hFF;
                end
                check("scan_dig", dig, e_dig);
                check("scan_seg", seg, e_seg);
                cj = ((since - 1) / D2) % N2;
                check("scan_dig4", dig4, 4'(~(4'd1 << cj)));
                check("scan_seg4", seg4, 8'hC0);
                if (idle) check("idle_miso", miso, 1);
            end
        end
    end

    task automatic send_bits(input logic [31:0] w, input int nb, output logic [31:0] rx);
        rx = 0;
        idle = 1'b0;
        ss = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = nb - 1; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = w[i];
            repeat (H) @(negedge clk);
            rx = {rx[30:0], miso};
            sclk = 1'b1;
            repeat (H) @(negedge clk);
        end
        chk_en = 1'b0;
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input logic [31:0] w, input int nb, input int tbl_err);
        int e0, me;
        logic [15:0] pre;
        logic [31:0] rx, exp_rx;
        e0 = err_cnt;
        pre = m_echo;
        send_bits(w, nb, rx);
        exp_rx = 0;
        for (int i = 0; i < nb; i++) exp_rx = {exp_rx[30:0], (i < 16) ? pre[15 - i] : 1'b1};
        check("miso_echo", rx, exp_rx);
        model_commit(w[15:0], nb, me);
        chk_en = 1'b1;
        idle = 1'b1;
        repeat (4) @(negedge clk);
        check("frame_err", err_cnt - e0, (tbl_err < 0) ? me : tbl_err);
    endtask

    task automatic probe(input int s, input logic [7:0] ed, input logic [7:0] es);
        int n;
        n = 0;
        while (!(since > 0 && ((since - 1) / D1) % N1 == s) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            vec_cnt++;
            miscmp++;
            $display("FAIL probe_timeout: slot %0d not reached within %0d cycles", s, n);
        end else begin
            check("probe_dig", dig, ed);
            check("probe_seg", seg, es);
        end
    endtask

    logic [3:0] seq4 [13] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hB, 4'hB, 4'hB,
                              4'h7, 4'h7, 4'h7, 4'hE};

    initial begin
        int e0, e40, r, nb;
        logic [3:0] cmd, addr;
        logic [7:0] data;
        logic [31:0] w;

        tbl[0]  = '{32'h3000,  16, 0, -1, 8'h00, 8'h00};
        tbl[1]  = '{32'h11AA,  16, 0,  1, 8'hFD, 8'h08};
        tbl[2]  = '{32'h3001,  16, 0, -1, 8'h00, 8'h00};
        tbl[3]  = '{32'h1255,  16, 0,  2, 8'hFB, 8'hAA};
        tbl[4]  = '{32'h20FE,  16, 0,  0, 8'hFF, 8'hFF};
        tbl[5]  = '{32'h0000,  16, 0,  1, 8'hFD, 8'h55};
        tbl[6]  = '{32'h20FF,  16, 0,  2, 8'hFB, 8'hAA};
        tbl[7]  = '{32'h3000,  16, 0,  1, 8'hFD, 8'h08};
        tbl[8]  = '{32'h0999,  15, 1,  1, 8'hFD, 8'h08};
        tbl[9]  = '{32'h12233, 17, 1,  2, 8'hFB, 8'h92};
        tbl[10] = '{32'h1933,  16, 1, -1, 8'h00, 8'h00};
        tbl[11] = '{32'h7000,  16, 1,  1, 8'hFD, 8'h08};
        tbl[12] = '{32'h1444,  16, 0,  4, 8'hEF, 8'h99};
        tbl[13] = '{32'h0000,  16, 0, -1, 8'h00, 8'h00};
        tbl[14] = '{32'hF123,  16, 1, -1, 8'h00, 8'h00};
        tbl[15] = '{32'h1708,  16, 0,  7, 8'h7F, 8'h80};
        tbl[16] = '{32'h1800,  16, 1, -1, 8'h00, 8'h00};
        tbl[17] = '{32'h2001,  16, 0,  0, 8'hFE, 8'hC0};
        tbl[18] = '{32'h20FF,  16, 0, -1, 8'h00, 8'h00};

        sclk = 1'b1; ss = 1'b1; ss4 = 1'b1; mosi = 1'b1; rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_dig", dig, 8'hFE);
        check("post_rst_seg", seg, 8'hC0);
        repeat (10) @(negedge clk);

        for (int k = 0; k < 19; k++) begin
            run_frame(tbl[k].frame, tbl[k].nb, tbl[k].err);
            if (tbl[k].slot >= 0) probe(tbl[k].slot, tbl[k].dig, tbl[k].seg);
        end

        // Mid-frame reset on both instances: no commit, no error, next frame needs a fresh ss fall.
        e0 = err_cnt;
        e40 = err4_cnt;
        w = 32'h1155;
        idle = 1'b0;
        ss = 1'b0;
        ss4 = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 15; i >= 6; i--) begin
            sclk = 1'b0; mosi = w[i]; repeat (H) @(negedge clk);
            sclk = 1'b1; repeat (H) @(negedge clk);
        end
        chk_en = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check("scan4_seq", dig4, seq4[k]);
        end
        for (int i = 5; i >= 0; i--) begin
            sclk = 1'b0; mosi = w[i]; repeat (H) @(negedge clk);
            sclk = 1'b1; repeat (H) @(negedge clk);
        end
        ss = 1'b1;
        ss4 = 1'b1;
        repeat (12) @(negedge clk);
        idle = 1'b1;
        check("abort_err", err_cnt - e0, 0);
        check("abort_err4", err4_cnt - e40, 0);
        probe(1, 8'hFD, 8'hC0);
        run_frame(32'h1155, 16, 0);
        probe(1, 8'hFD, 8'h92);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? 4'(r) : ((r < 8) ? 4'h1 : 4'($urandom_range(4, 15)));
            addr = 4'($urandom_range(0, 9));
            data = 8'($urandom);
            r = $urandom_range(0, 7);
            nb = (r == 0) ? 15 : ((r == 1) ? 17 : 16);
            w = {15'd0, 1'($urandom_range(0, 1)), cmd, addr, data};
            if (nb == 15) w = {17'd0, w[14:0]};
            if (nb == 16) w = {16'd0, w[15:0]};
            run_frame(w, nb, -1);
        end

        repeat (20) @(negedge clk);
        check("err4_total", err4_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vec_cnt);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_display_ctrl.md
SPI_DISPLAY_CTRL -- requirements
Module: spi_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 5000, clock_i cycles per digit slot; minimum 2.
REQ-003 clock_i  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 spi_sclk_i  input  1  SPI clock, asynchronous to clock_i; idle high; rising edge samples MOSI; frequency at most clock_i/4.
REQ-006 spi_ss_i  input  1  SPI slave select, active-low, idle high.
REQ-007 spi_mosi_i  input  1  SPI data in, MSB first.
REQ-008 spi_miso_o  output  1  SPI data out; high while spi_ss_i is high.
REQ-009 segment_o  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 digit_o  output  NUM_DIGITS  active-low one-hot digit strobe.
REQ-011 frame_err_o  output  1  one-cycle pulse on a rejected frame.

Function
REQ-012 spi_sclk_i, spi_ss_i and spi_mosi_i each pass through a 2-flop synchroniser; edges are detected on the synchronised signals only.
REQ-013 Synchronised ss falling edge clears the bit counter; the counter saturates at 17.
REQ-014 Each synchronised sclk rising edge with ss low shifts MOSI into a 16-bit shift register and increments the counter.
REQ-015 Frame layout: [15:12] cmd, [11:8] addr, [7:0] data.
REQ-016 On the synchronised ss rising edge, the frame commits only if the count equals exactly 16; otherwise it is discarded and frame_err_o pulses.
REQ-017 Commit occurs 1 cycle after the ss rising edge is detected; the register change is visible at most 4 clock_i cycles after the physical ss rise.
REQ-018 cmd 0x1: digit register[addr] <= data.
  - If addr >= NUM_DIGITS, no write occurs and frame_err_o pulses.
REQ-019 cmd 0x2: enable mask <= data[NUM_DIGITS-1:0].
REQ-020 cmd 0x3: mode <= data[0], where 0 = hex decode and 1 = raw.
REQ-021 cmd 0x0: no operation, no error.
REQ-022 Any other cmd is ignored and frame_err_o pulses.
REQ-023 Hex mode segment output:
  - segment_o[6:0] is the active-low 7-segment pattern of digit register bits [3:0] (0-F);
  - segment_o[7] = ~bit7;
  - bits [6:4] are ignored.
REQ-024 Raw mode: segment_o = ~digit register.
REQ-025 MISO echoes the last committed valid frame (0x0000 after reset), MSB first.
  - First bit is driven on the synchronised ss fall.
  - Subsequent bits change on each synchronised sclk falling edge.
  - After 16 bits, MISO outputs 1.
REQ-026 Scan counter counts 0..SCAN_DIV-1.
  - At wrap, the digit index advances by 1, from NUM_DIGITS-1 back to 0.
REQ-027 Outputs for the current index are registered.
  - If the index's mask bit = 1: digit_o has a low bit at that index; segment_o is decoded from that digit's register.
  - If the mask bit = 0: digit_o = all ones and segment_o = 8'hFF.
REQ-028 A register write mid-slot takes effect on segment_o the cycle after commit; no wait for the next slot.
REQ-029 An ss rise and a scan wrap in the same cycle are independent; both take effect.
REQ-030 A glitch-free frame of more than 16 bits (count 17) is rejected in full.

Reset
REQ-031 While rst_i is high, all of the following hold:
  - digit registers = 0x00; mask = all ones; mode = 0;
  - echo register = 0x0000; bit counter = 0; shift register = 0;
  - scan counter = 0; index = 0;
  - segment_o = 8'hFF; digit_o = all ones; spi_miso_o = 1; frame_err_o = 0;
  - synchronisers are loaded with the idle value 1.
REQ-032 The first cycle after rst_i falls, digit_o selects index 0 and segment_o shows the hex-0 pattern 8'hC0.
REQ-033 rst_i asserted mid-frame aborts the frame with no commit and no frame_err_o; the next frame must begin with a fresh ss falling edge.

Verification
REQ-034 Frame 0x11AA with hex mode, then wait for slot 1 -> digit_o = 8'b1111_1101, segment_o = 8'h08 (dp on, "A").
REQ-035 Frame 0x3001, then frame 0x1255 -> mode = raw; in slot 2, segment_o = 8'hAA.
REQ-036 Frame 0x20FE -> slot 0 has digit_o = 8'hFF and segment_o = 8'hFF; slot 1 lights normally.
REQ-037 Frame with 15 bits, frame with 17 bits, frame 0x19_33 (addr 9 with NUM_DIGITS = 8), and frame 0x7000 -> frame_err_o pulses 4 times; no register changes.
REQ-038 Frame 0x1444, then frame 0x0000 -> MISO during the second frame reads back 0x1444.
REQ-039 Run with NUM_DIGITS = 4 and SCAN_DIV = 3 -> digit_o cycles 1110, 1101, 1011, 0111, 1110 with a 3-cycle period per slot; rst_i asserted mid-frame -> no write occurs.
